// File: rtl/song_if.sv
// Bundle between the song sequencer, the song ROM, the user controls and the
// frequency lookup.
interface song_if #(
    parameter int ADDR_W = 6
);
    // start/stop are single-cycle pulses and pause is a level. All three are
    // sampled on the rising clock edge. The ROM answers rom_addr with rom_data
    // one cycle later.
    logic              start;
    logic              stop;
    logic              pause;
    logic [4:0]        key_note;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [4:0]        music;
    logic              playing;
    logic              done;
    logic [2:0]        dbg_state;

    modport master (
        output start, stop, pause, key_note, rom_data,
        input  rom_addr, music, playing, done, dbg_state
    );

    modport slave (
        input  start, stop, pause, key_note, rom_data,
        output rom_addr, music, playing, done, dbg_state
    );
endinterface

// File: rtl/song_sequencer.sv
// Autoplay sequencer: walks a song ROM of {dur, note} entries and holds each
// note for dur beats, ending with a short silence. Live keys override the output.
module song_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 6
) (
    input  logic  clk,
    input  logic  rst_n,
    song_if.slave bus
);
    localparam int CNT_W = $clog2(7 * BEAT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [4:0]        MAX_NOTE  = 5'd21;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        cur_note_q, cur_note_d;
    logic [4:0]        music_q, music_d;
    logic              done_q, done_d;
    logic [2:0]        rom_dur;
    logic [4:0]        rom_note;
    logic [4:0]        seq_note;
    logic              key_ok;

    assign rom_dur  = bus.rom_data[7:5];
    assign rom_note = bus.rom_data[4:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        cur_note_d = cur_note_q;
        done_d     = 1'b0;
        if (bus.stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else if (!bus.pause) begin
            case (state_q)
                S_IDLE: begin
                    addr_d = '0;
                    if (bus.start) state_d = S_FETCH;
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (rom_dur == 3'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        addr_d  = '0;
                    end else begin
                        // Out-of-range note codes are stored as silence.
                        cur_note_d = (rom_note != 5'd0 && rom_note <= MAX_NOTE) ? rom_note : 5'd0;
                        cnt_d      = CNT_W'(int'(rom_dur) * BEAT_CYCLES - GAP_CYCLES - 1);
                        state_d    = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The sequencer keeps running underneath a held key.
    assign seq_note = (state_q == S_PLAY && !bus.pause) ? cur_note_q : 5'd0;
    assign key_ok   = (bus.key_note != 5'd0) && (bus.key_note <= MAX_NOTE);
    assign music_d  = key_ok ? bus.key_note : seq_note;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            cur_note_q <= '0;
            music_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            cur_note_q <= cur_note_d;
            music_q    <= music_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.music     = music_q;
    assign bus.playing   = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Autoplay controller that drives the 5-bit note code into the note-to-frequency lookup. It walks a song ROM of `{duration, note}` entries and holds each note for its programmed number of beats. A short silence gap follows each note. Live keyboard input takes priority over the autoplay stream on the shared `music` output. The block sits between the song ROM / user controls and the frequency lookup plus tone generator.

## Interface
Parameters:
- `BEAT_CYCLES`, default 25_000_000: clock cycles per beat; must be greater than `GAP_CYCLES`.
- `GAP_CYCLES`, default 2_500_000: silence cycles at the end of each note; must be ≥ 1.
- `ADDR_W`, default 6: song ROM address width.

Ports:
- `clk`, in, 1: system clock; all logic rising-edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: one-cycle pulse; begins playback from address 0 when idle.
- `stop`, in, 1: one-cycle pulse; aborts playback and returns to idle.
- `pause`, in, 1: level; freezes the sequencer while high.
- `key_note`, in, 5: live key code; 0 means no key pressed; valid codes are 1..21.
- `rom_addr`, out, `ADDR_W`: song ROM address.
- `rom_data`, in, 8: `{dur[7:5], note[4:0]}`; synchronous ROM, valid 1 cycle after `rom_addr`.
- `music`, out, 5: note code to the frequency lookup; 0 means silence.
- `playing`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at natural end of song.

## Operation
States: IDLE, FETCH, LOAD, PLAY, GAP.

- **IDLE**
  - `rom_addr` = 0.
  - `start` → FETCH.
- **FETCH**
  - `rom_addr` holds the current index.
  - → LOAD after 1 cycle.
- **LOAD**
  - Capture `rom_data`.
  - If `dur` = 0, the entry is the end marker: pulse `done`, → IDLE.
  - Otherwise latch `cur_note` = `note`, load the counter with `dur*BEAT_CYCLES − GAP_CYCLES − 1`, → PLAY.
- **PLAY**
  - Counter decrements.
  - At 0: load `GAP_CYCLES − 1`, → GAP.
- **GAP**
  - Counter decrements.
  - At 0, if `rom_addr` = 2^`ADDR_W` − 1: pulse `done`, → IDLE. The address does not wrap.
  - Otherwise `rom_addr` + 1, → FETCH.
- **Pause**
  - While `pause` = 1, state, counter and address are frozen.
  - `start` is ignored while paused.
- **Stop**
  - `stop` → IDLE from any state on the next edge.
  - `rom_addr` = 0 and `done` is not pulsed.
  - `stop` beats `start` and `pause` when they coincide.
  - `start` outside IDLE is ignored, so there is no restart.
- **Sequencer note**
  - `seq_note` = `cur_note` when state = PLAY and `pause` = 0.
  - `seq_note` = 0 otherwise: in IDLE, FETCH, LOAD, GAP, and while paused.
- **Arbitration of the `music` output**
  - Registered: `music` ← `key_note` if `key_note` is in 1..21, else `seq_note`.
  - `key_note` values 22..31 are treated as no key.
  - Key override does not affect sequencer timing; autoplay keeps advancing underneath.
- **Note codes**
  - ROM `note` values 22..31 play as 0 (silence) for their full duration.
- **Counter width**
  - Sized for `7*BEAT_CYCLES` with no overflow.

## Timing
- **Reset values**
  - State = IDLE; `rom_addr` = 0, `music` = 0, `playing` = 0, `done` = 0.
  - Counter = 0, `cur_note` = 0.
- **Start latency**
  - `start` at edge N: FETCH at N+1, LOAD at N+2, PLAY at N+3.
  - `music` shows the note from edge N+4, one register stage after PLAY.
- **Per-entry period**
  - `dur*BEAT_CYCLES + 2` cycles: PLAY `dur*BEAT_CYCLES − GAP_CYCLES`, GAP `GAP_CYCLES`, plus FETCH and LOAD.
  - Added pause cycles extend the period one-for-one.
- **`done`**
  - Exactly one cycle, asserted in the cycle the FSM enters IDLE.
  - `playing` falls on the same edge.
- **`pause` mid-PLAY**
  - `music` drops to 0 one cycle after `pause` rises.
  - On release, the note resumes with the remaining count intact.
- **Asynchronous reset mid-note**
  - All outputs go to reset values immediately, with no clock required.

## Test plan
Bench parameters: `BEAT_CYCLES` = 10, `GAP_CYCLES` = 2, `ADDR_W` = 3.

1. **Basic song.** ROM `{1,8}`, `{2,12}`, `{0,0}`; pulse `start`.
   - `music` = 8 for 8 cycles, 0 for 4 cycles (GAP + FETCH + LOAD), then 12 for 18 cycles, then 0.
   - `done` pulses once; `playing` falls with it.
2. **Full ROM, no end marker.** 8 entries, each `dur` = 1.
   - After entry 7's GAP, `done` pulses and the FSM enters IDLE with `rom_addr` = 0.
   - No wrap to entry 0.
3. **Pause.** Assert `pause` for 5 cycles, 3 cycles into a `dur` = 1 note.
   - `music` = 0 during the pause.
   - The note plays its remaining 5 cycles after release; the total period is 17 cycles.
4. **Stop.** Pulse `stop` during PLAY, together with `start`.
   - IDLE on the next edge; `music` = 0 one cycle later.
   - `rom_addr` = 0; no `done` pulse.
   - A later `start` replays from entry 0.
5. **Key override.** `key_note` = 15 during autoplay of note 8, then `key_note` = 25.
   - `music` = 15 while key 15 is held.
   - With `key_note` = 25, `music` reverts to the sequencer note.
   - The sequencer's per-note timing is unchanged from scenario 1.
6. **Reset.** Drop `rst_n` asynchronously mid-PLAY.
   - `music`, `playing`, `done` and `rom_addr` go to 0 before the next clock edge.
   - After reset, `start` plays normally.
